// File: rtl/sprite_compositor.sv
// sprite_compositor
// Turns the scan position and sprite positions into sprite ROM byte addresses,
// then composites the returned RGB565 words over the background. The stage
// state travels alongside the ROM read, and each pixel strobe yields one
// registered output pixel. Sticky per-frame collision flags are kept for the
// game logic.
module sprite_compositor #(
    parameter int          BALL_W   = 16,
    parameter int          BALL_H   = 16,
    parameter int          BAR_W    = 16,
    parameter int          BAR_H    = 64,
    parameter int          RD_LAT   = 4,
    parameter logic [15:0] TKEY     = 16'hF81F,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic [10:0] hcnt,
    input  logic [10:0] vcnt,
    input  logic        video_on,
    input  logic        frame_start,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    input  logic [9:0]  bar_a_x,
    input  logic [9:0]  bar_a_y,
    input  logic [9:0]  bar_b_x,
    input  logic [9:0]  bar_b_y,
    output logic [8:0]  addr,
    output logic [10:0] addr_bar_a,
    output logic [10:0] addr_bar_b,
    input  logic [15:0] data_ball,
    input  logic [15:0] data_bar_a,
    input  logic [15:0] data_bar_b,
    output logic [15:0] rgb_out,
    output logic        rgb_valid,
    output logic        ball_hit_a,
    output logic        ball_hit_b
);

    // Everything is widened to 12 bits so that a box ending past column 1023
    // does not wrap around and falsely match small columns.
    logic [11:0] w_h;
    logic [11:0] w_v;
    logic [11:0] w_ballX;
    logic [11:0] w_ballY;
    logic [11:0] w_barAX;
    logic [11:0] w_barAY;
    logic [11:0] w_barBX;
    logic [11:0] w_barBY;

    assign w_h     = {1'b0, hcnt};
    assign w_v     = {1'b0, vcnt};
    assign w_ballX = {2'b00, ball_x};
    assign w_ballY = {2'b00, ball_y};
    assign w_barAX = {2'b00, bar_a_x};
    assign w_barAY = {2'b00, bar_a_y};
    assign w_barBX = {2'b00, bar_b_x};
    assign w_barBY = {2'b00, bar_b_y};

    // In-box flags already include video_on, so blanking suppresses both the
    // address and everything downstream that depends on the flags.
    logic w_inBall;
    logic w_inA;
    logic w_inB;

    assign w_inBall = video_on
                   && (w_h >= w_ballX) && (w_h < w_ballX + 12'(BALL_W))
                   && (w_v >= w_ballY) && (w_v < w_ballY + 12'(BALL_H));
    assign w_inA    = video_on
                   && (w_h >= w_barAX) && (w_h < w_barAX + 12'(BAR_W))
                   && (w_v >= w_barAY) && (w_v < w_barAY + 12'(BAR_H));
    assign w_inB    = video_on
                   && (w_h >= w_barBX) && (w_h < w_barBX + 12'(BAR_W))
                   && (w_v >= w_barBY) && (w_v < w_barBY + 12'(BAR_H));

    // Linear pixel index inside each sprite; the byte address is twice that.
    logic [11:0] w_ballLin;
    logic [11:0] w_barALin;
    logic [11:0] w_barBLin;

    assign w_ballLin = (w_v - w_ballY) * 12'(BALL_W) + (w_h - w_ballX);
    assign w_barALin = (w_v - w_barAY) * 12'(BAR_W)  + (w_h - w_barAX);
    assign w_barBLin = (w_v - w_barBY) * 12'(BAR_W)  + (w_h - w_barBX);

    logic [8:0]  r_addrBall;
    logic [10:0] r_addrA;
    logic [10:0] r_addrB;

    // Update the ROM addresses only on a pixel strobe so they stay stable for
    // the two clocks the ROM controller needs between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addrBall <= '0;
            r_addrA    <= '0;
            r_addrB    <= '0;
        end else if (pix_en) begin
            r_addrBall <= w_inBall ? {w_ballLin[7:0], 1'b0} : 9'd0;
            r_addrA    <= w_inA    ? {w_barALin[9:0], 1'b0} : 11'd0;
            r_addrB    <= w_inB    ? {w_barBLin[9:0], 1'b0} : 11'd0;
        end
    end

    // Delay line entry layout: {pix_en, video_on, in_ball, in_a, in_b}.
    logic [4:0]              w_dlyIn;
    logic [RD_LAT-1:0][4:0]  r_dly;
    logic [4:0]              w_tap;

    assign w_dlyIn = {pix_en, video_on, w_inBall, w_inA, w_inB};
    assign w_tap   = r_dly[RD_LAT-1];

    // Carry the stage-0 context forward every clock so it lines up with the
    // ROM words arriving RD_LAT clocks after the address update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= '0;
        end else begin
            r_dly <= {r_dly[RD_LAT-2:0], w_dlyIn};
        end
    end

    logic w_tPix;
    logic w_tVid;
    logic w_opBall;
    logic w_opA;
    logic w_opB;

    assign w_tPix   = w_tap[4];
    assign w_tVid   = w_tap[3];
    assign w_opBall = w_tap[2] && (data_ball  != TKEY);
    assign w_opA    = w_tap[1] && (data_bar_a != TKEY);
    assign w_opB    = w_tap[0] && (data_bar_b != TKEY);

    logic [15:0] w_pixel;

    // Fixed priority: ball over bar A over bar B over background; blanking wins.
    always_comb begin
        w_pixel = BG_COLOR;
        if (!w_tVid) begin
            w_pixel = 16'h0000;
        end else if (w_opBall) begin
            w_pixel = data_ball;
        end else if (w_opA) begin
            w_pixel = data_bar_a;
        end else if (w_opB) begin
            w_pixel = data_bar_b;
        end
    end

    logic [15:0] r_rgb;
    logic        r_rgbValid;

    // Register the composited pixel; it holds until the next strobe arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb      <= '0;
            r_rgbValid <= 1'b0;
        end else begin
            r_rgbValid <= w_tPix;
            if (w_tPix) begin
                r_rgb <= w_pixel;
            end
        end
    end

    logic w_setA;
    logic w_setB;
    logic r_hitA;
    logic r_hitB;

    assign w_setA = w_tPix && w_opBall && w_opA;
    assign w_setB = w_tPix && w_opBall && w_opB;

    // Sticky collision flags; a hit landing on the frame_start clock is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hitA <= 1'b0;
            r_hitB <= 1'b0;
        end else begin
            if (w_setA) begin
                r_hitA <= 1'b1;
            end else if (frame_start) begin
                r_hitA <= 1'b0;
            end
            if (w_setB) begin
                r_hitB <= 1'b1;
            end else if (frame_start) begin
                r_hitB <= 1'b0;
            end
        end
    end

    assign addr       = r_addrBall;
    assign addr_bar_a = r_addrA;
    assign addr_bar_b = r_addrB;
    assign rgb_out    = r_rgb;
    assign rgb_valid  = r_rgbValid;
    assign ball_hit_a = r_hitA;
    assign ball_hit_b = r_hitB;

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor
// Drives scan positions and sprite placements, plays the sprite ROMs, and
// compares every output each clock with a pixel-level model of the compositor.
module tb_sprite_compositor;

    localparam int          RD_LAT = 4;
    localparam logic [15:0] TKEY   = 16'hF81F;
    localparam logic [15:0] BG     = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        video_on = 1'b0;
    logic        frame_start = 1'b0;
    logic [10:0] hcnt = '0;
    logic [10:0] vcnt = '0;
    logic [9:0]  ball_x = '0, ball_y = '0;
    logic [9:0]  bar_a_x = '0, bar_a_y = '0;
    logic [9:0]  bar_b_x = '0, bar_b_y = '0;
    logic [15:0] data_ball, data_bar_a, data_bar_b;
    logic [8:0]  addr;
    logic [10:0] addr_bar_a, addr_bar_b;
    logic [15:0] rgb_out;
    logic        rgb_valid, ball_hit_a, ball_hit_b;

    int checks = 0;
    int failures = 0;

    sprite_compositor #(
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .video_on    (video_on),
        .frame_start (frame_start),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .bar_a_x     (bar_a_x),
        .bar_a_y     (bar_a_y),
        .bar_b_x     (bar_b_x),
        .bar_b_y     (bar_b_y),
        .addr        (addr),
        .addr_bar_a  (addr_bar_a),
        .addr_bar_b  (addr_bar_b),
        .data_ball   (data_ball),
        .data_bar_a  (data_bar_a),
        .data_bar_b  (data_bar_b),
        .rgb_out     (rgb_out),
        .rgb_valid   (rgb_valid),
        .ball_hit_a  (ball_hit_a),
        .ball_hit_b  (ball_hit_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ROM contents indexed by word (byte address / 2)
    logic [15:0] romBall [256];
    logic [15:0] romA    [1024];
    logic [15:0] romB    [1024];
    logic [8:0]  histBall [RD_LAT];
    logic [10:0] histA    [RD_LAT];
    logic [10:0] histB    [RD_LAT];

    // ROM controller stand-in: words for an address appear RD_LAT clocks later
    always @(negedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
            histBall[i] = histBall[i-1];
            histA[i]    = histA[i-1];
            histB[i]    = histB[i-1];
        end
        histBall[0] = addr;
        histA[0]    = addr_bar_a;
        histB[0]    = addr_bar_b;
        data_ball   = romBall[histBall[RD_LAT-1][8:1]];
        data_bar_a  = romA[histA[RD_LAT-1][10:1]];
        data_bar_b  = romB[histB[RD_LAT-1][10:1]];
    end

    // Behavioural model
    typedef struct {
        int          due;
        logic [15:0] rgb;
        bit          hA;
        bit          hB;
    } ent_t;

    ent_t        pend[$];
    int          cyc = 0;
    logic [8:0]  eAddr = '0;
    logic [10:0] eAddrA = '0, eAddrB = '0;
    logic [15:0] eRgb = '0;
    bit          eValid = 0, eHitA = 0, eHitB = 0;

    function automatic void boxAddr(input int h, input int v, input int x, input int y,
                                    input int w, input int ht, input int span,
                                    output bit inBox, output int a);
        inBox = (h >= x) && (h < x + w) && (v >= y) && (v < y + ht);
        a = inBox ? (((v - y) * w + (h - x)) * 2) % span : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        ent_t        e;
        bit          sA, sB, inBl, inA, inB, opBl, opA, opB;
        int          aBl, aA, aB;
        logic [15:0] dBl, dA, dB, px;
        if (!rst_n) begin
            pend.delete();
            eAddr = '0; eAddrA = '0; eAddrB = '0;
            eRgb = '0; eValid = 0; eHitA = 0; eHitB = 0;
        end else begin
            cyc++;
            sA = 0; sB = 0; eValid = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e = pend.pop_front();
                eValid = 1; eRgb = e.rgb; sA = e.hA; sB = e.hB;
            end
            eHitA = sA ? 1'b1 : (frame_start ? 1'b0 : eHitA);
            eHitB = sB ? 1'b1 : (frame_start ? 1'b0 : eHitB);
            if (pix_en) begin
                boxAddr(int'(hcnt), int'(vcnt), int'(ball_x),  int'(ball_y),  16, 16, 512,  inBl, aBl);
                boxAddr(int'(hcnt), int'(vcnt), int'(bar_a_x), int'(bar_a_y), 16, 64, 2048, inA,  aA);
                boxAddr(int'(hcnt), int'(vcnt), int'(bar_b_x), int'(bar_b_y), 16, 64, 2048, inB,  aB);
                if (!video_on) begin
                    inBl = 0; inA = 0; inB = 0; aBl = 0; aA = 0; aB = 0;
                end
                eAddr = 9'(aBl); eAddrA = 11'(aA); eAddrB = 11'(aB);
                dBl = romBall[aBl / 2]; dA = romA[aA / 2]; dB = romB[aB / 2];
                opBl = inBl && (dBl != TKEY);
                opA  = inA  && (dA  != TKEY);
                opB  = inB  && (dB  != TKEY);
                if (!video_on)  px = 16'h0000;
                else if (opBl)  px = dBl;
                else if (opA)   px = dA;
                else if (opB)   px = dB;
                else            px = BG;
                e.due = cyc + RD_LAT; e.rgb = px; e.hA = opBl && opA; e.hB = opBl && opB;
                pend.push_back(e);
            end
        end
    end

    // Continuous comparison against the model
    always @(negedge clk) begin
        checkOutput("addr",       32'(addr),       32'(eAddr));
        checkOutput("addr_bar_a", 32'(addr_bar_a), 32'(eAddrA));
        checkOutput("addr_bar_b", 32'(addr_bar_b), 32'(eAddrB));
        checkOutput("rgb_valid",  32'(rgb_valid),  32'(eValid));
        checkOutput("rgb_out",    32'(rgb_out),    32'(eRgb));
        checkOutput("ball_hit_a", 32'(ball_hit_a), 32'(eHitA));
        checkOutput("ball_hit_b", 32'(ball_hit_b), 32'(eHitB));
    end

    // One pixel strobe followed by the idle phase (called just after an edge)
    task automatic applyStimulus(input int h, input int v, input bit vid, input bit fs);
        hcnt = 11'(h); vcnt = 11'(v); video_on = vid; pix_en = 1'b1; frame_start = fs;
        @(posedge clk); #1;
        pix_en = 1'b0; frame_start = 1'b0;
        @(posedge clk); #1;
    endtask

    // Strobe one pixel, measure the strobe-to-valid latency and check the pixel
    task automatic pixelLatency(input int h, input int v, input bit vid, input logic [15:0] expRgb,
                                input int fsAt, input string nm);
        int n;
        hcnt = 11'(h); vcnt = 11'(v); video_on = vid; pix_en = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            pix_en = 1'b0;
            n++;
            frame_start = (n == fsAt);
        end while (!rgb_valid && n < 20);
        frame_start = 1'b0;
        checkOutput({nm, "_latency"}, 32'(n), 32'(RD_LAT + 1));
        checkOutput({nm, "_rgb"}, 32'(rgb_out), 32'(expRgb));
        @(posedge clk); #1;
        checkOutput({nm, "_pulse"}, 32'(rgb_valid), 32'd0);
    endtask

    task automatic fsPulse();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic placeSprites(input int bx, input int by, input int ax, input int ay,
                                input int cx, input int cy);
        ball_x = 10'(bx); ball_y = 10'(by);
        bar_a_x = 10'(ax); bar_a_y = 10'(ay);
        bar_b_x = 10'(cx); bar_b_y = 10'(cy);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++)
            romBall[i] = ($urandom_range(0, 3) == 0) ? TKEY : 16'($urandom);
        for (int i = 0; i < 1024; i++) begin
            romA[i] = ($urandom_range(0, 3) == 0) ? TKEY : 16'($urandom);
            romB[i] = ($urandom_range(0, 3) == 0) ? TKEY : 16'($urandom);
        end
        for (int i = 0; i < RD_LAT; i++) begin
            histBall[i] = '0; histA[i] = '0; histB[i] = '0;
        end

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_rgb_valid", 32'(rgb_valid), 32'd0);
        checkOutput("reset_addr",      32'(addr),      32'd0);

        // Address generation and hold
        placeSprites(100, 50, 600, 600, 700, 700);
        hcnt = 11'd103; vcnt = 11'd52; video_on = 1'b1; pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        checkOutput("addr_ball_046", 32'(addr),       32'h046);
        checkOutput("addr_bar_a_0",  32'(addr_bar_a), 32'd0);
        checkOutput("addr_bar_b_0",  32'(addr_bar_b), 32'd0);
        @(posedge clk); #1;
        checkOutput("addr_hold", 32'(addr), 32'h046);
        repeat (RD_LAT + 2) @(posedge clk);
        #1;

        // Latency, priority and collision flags
        fsPulse();
        placeSprites(100, 50, 96, 40, 700, 700);
        romBall[35] = 16'h07E0;
        romA[199]   = 16'h001F;
        pixelLatency(103, 52, 1'b1, 16'h07E0, 0, "prio_ball");
        checkOutput("hit_a_set",  32'(ball_hit_a), 32'd1);
        checkOutput("hit_b_idle", 32'(ball_hit_b), 32'd0);
        @(posedge clk); #1;
        checkOutput("hit_a_held", 32'(ball_hit_a), 32'd1);
        fsPulse();
        checkOutput("hit_a_clear", 32'(ball_hit_a), 32'd0);
        pixelLatency(103, 52, 1'b1, 16'h07E0, RD_LAT, "fs_coincident");
        checkOutput("hit_a_set_wins", 32'(ball_hit_a), 32'd1);

        // Asynchronous reset mid-stream discards the pipeline
        hcnt = 11'd103; vcnt = 11'd52; video_on = 1'b1; pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_addr",      32'(addr),       32'd0);
        checkOutput("async_rgb_out",   32'(rgb_out),    32'd0);
        checkOutput("async_rgb_valid", 32'(rgb_valid),  32'd0);
        checkOutput("async_hit_a",     32'(ball_hit_a), 32'd0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pixelLatency(103, 52, 1'b1, 16'h07E0, 0, "post_reset");

        // Transparency, background and blanking
        fsPulse();
        placeSprites(300, 300, 800, 800, 296, 296);
        romBall[35] = TKEY;
        romB[103]   = 16'hFFE0;
        pixelLatency(303, 302, 1'b1, 16'hFFE0, 0, "transparent_ball");
        checkOutput("hit_b_transparent", 32'(ball_hit_b), 32'd0);
        pixelLatency(500, 500, 1'b1, BG, 0, "background");
        pixelLatency(303, 302, 1'b0, 16'h0000, 0, "blanked");

        // Right-edge boundary: no wrap at column 1023
        placeSprites(1020, 10, 600, 600, 700, 700);
        hcnt = 11'd1023; vcnt = 11'd10; video_on = 1'b1; pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        checkOutput("edge_addr_dx3", 32'(addr), 32'h006);
        @(posedge clk); #1;
        hcnt = 11'd1036; pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        checkOutput("edge_addr_outside", 32'(addr), 32'd0);
        @(posedge clk); #1;

        // Randomized scenes checked against the model
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 4) == 0) begin
                placeSprites(1008 + $urandom_range(0, 15), 200 + $urandom_range(0, 20),
                             1008 + $urandom_range(0, 15), 170 + $urandom_range(0, 40),
                             1008 + $urandom_range(0, 15), 170 + $urandom_range(0, 40));
                for (int p = 0; p < 40; p++)
                    applyStimulus(1000 + $urandom_range(0, 47), 165 + $urandom_range(0, 110),
                                  $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0);
            end else begin
                placeSprites(200 + $urandom_range(0, 40), 200 + $urandom_range(0, 40),
                             200 + $urandom_range(0, 40), 160 + $urandom_range(0, 60),
                             200 + $urandom_range(0, 40), 160 + $urandom_range(0, 60));
                for (int p = 0; p < 40; p++)
                    applyStimulus(195 + $urandom_range(0, 70), 155 + $urandom_range(0, 110),
                                  $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0);
            end
        end

        repeat (RD_LAT + 3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Pixel-pipeline stage upstream and downstream of the sprite ROM controller.
- Turns the VGA scan position plus ball/bar positions into ROM byte addresses (ball 9-bit, bar_a/bar_b 11-bit).
- Consumes the returned 16-bit RGB565 words and composites them over a background colour with transparency and fixed priority.
- Emits one registered pixel per pixel strobe and per-frame sticky ball/bar collision flags for the game logic.

Parameters:
- BALL_W, 16, ball sprite width in pixels (power of 2).
- BALL_H, 16, ball sprite height; BALL_W*BALL_H*2 <= 512 bytes.
- BAR_W, 16, bar sprite width (power of 2).
- BAR_H, 64, bar sprite height; BAR_W*BAR_H*2 <= 2048 bytes.
- RD_LAT, 4, clk cycles from the address-update edge to valid ROM words on data inputs (range 2..8).
- TKEY, 16'hF81F, transparent colour key.
- BG_COLOR, 16'h0000, background colour.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_en  in  1  pixel strobe, high one clk in every two, aligned with the ROM controller phase.
- hcnt  in  11  current pixel column.
- vcnt  in  11  current pixel row.
- video_on  in  1  active display region.
- frame_start  in  1  one-clk pulse at start of frame.
- ball_x, ball_y  in  10 each  ball top-left corner.
- bar_a_x, bar_a_y  in  10 each  bar A top-left corner.
- bar_b_x, bar_b_y  in  10 each  bar B top-left corner.
- addr  out  9  ball ROM byte address (even).
- addr_bar_a  out  11  bar A ROM byte address (even).
- addr_bar_b  out  11  bar B ROM byte address (even).
- data_ball  in  16  ball pixel word from ROM controller.
- data_bar_a  in  16  bar A pixel word.
- data_bar_b  in  16  bar B pixel word.
- rgb_out  out  16  composited RGB565 pixel.
- rgb_valid  out  1  one-clk pulse, rgb_out valid.
- ball_hit_a  out  1  sticky: ball and bar A overlapped (opaque) this frame.
- ball_hit_b  out  1  sticky: ball and bar B overlapped this frame.

Behaviour:
- Reset (async assert, sync release): all outputs 0; delay line cleared; no rgb_valid until a new pix_en travels the full pipe.
- Stage 0 (on the clk with pix_en=1):
  - Compute in-box flags with 12-bit unsigned compare, so no wrap near 1023. Ball: in_ball = hcnt>=ball_x && hcnt<ball_x+BALL_W && vcnt>=ball_y && vcnt<ball_y+BALL_H. Bars likewise.
  - Register addresses: addr = ((vcnt-ball_y)*BALL_W + (hcnt-ball_x))*2, truncated to 9 bits. Default geometry gives {dy[3:0],dx[3:0],1'b0}; bars give {dy[5:0],dx[3:0],1'b0}.
  - Outside a sprite box, or when video_on=0, that sprite's address = 0 and its in-flag = 0.
  - Addresses are held stable between pix_en strobes, two clks, as the ROM controller requires.
- Delay line: RD_LAT-deep shift register carrying {pix_en, video_on, in_ball, in_a, in_b}, shifted every clk.
- Output stage (delayed pix_en=1): sample the data inputs.
  - op_ball = in_ball && data_ball!=TKEY; op_a and op_b likewise.
  - Priority: ball > bar A > bar B > BG_COLOR. Delayed video_on=0 forces rgb_out=16'h0000.
  - rgb_out registered; rgb_valid high exactly one clk.
  - Latency from pix_en to rgb_valid = RD_LAT+1 clks.
- rgb_out holds its value between pulses.
- Collision flags:
  - ball_hit_a sets when op_ball && op_a at the output stage; ball_hit_b likewise.
  - Both clear on frame_start.
  - Simultaneous frame_start and set event: set wins (flag = 1).
- pix_en asserted two consecutive clks (protocol violation): each strobe is processed independently; no lockup. Data correctness is not guaranteed.
- Reset mid-line: pipeline contents discarded; first rgb_valid after release is RD_LAT+1 clks after the first pix_en.

Test Plan:
- Reset: rst_n=0 mid-stream -> all outputs 0 immediately (async). After release, no rgb_valid until RD_LAT+1 clks after first pix_en.
- Address generation: ball at (100,50), hcnt=103, vcnt=52, pix_en -> addr=9'h046 ({4'd2,4'd3,0}), addr_bar_a=addr_bar_b=0. Address held for 2 clks.
- Latency/priority: ROM model returns ball=16'h07E0, bar_a=16'h001F, both boxes hit -> rgb_out=16'h07E0, rgb_valid exactly RD_LAT+1 clks after pix_en.
- Transparency: ball word = 16'hF81F over bar B word 16'hFFE0 -> rgb_out=16'hFFE0, ball_hit_b stays 0. Neither sprite hit -> rgb_out=BG_COLOR. video_on=0 -> 16'h0000.
- Boundary: ball_x=1020, hcnt=1023 -> in_ball=1, addr dx=3. hcnt=1036 -> outside, addr=0 (no 10-bit wrap).
- Collision flags: opaque ball/bar A overlap -> ball_hit_a=1 and held. frame_start alone -> 0. frame_start coincident with overlap -> stays 1.
